// File: rtl/conv3x3_engine_if.sv
// Stream bundle between the line-buffer taps and the 3x3 convolution engine.
// The master drives window columns and kernel loads; the slave returns result pixels.
interface conv3x3_engine_if;
  logic        in_valid;
  logic [7:0]  top;
  logic [7:0]  mid;
  logic [7:0]  bot;
  logic        kernel_load;
  logic [71:0] coeff;
  logic        out_valid;
  logic [7:0]  out_pixel;
  logic [15:0] out_x;
  logic [15:0] out_y;
  logic        frame_done;

  modport master (
    output in_valid, top, mid, bot, kernel_load, coeff,
    input  out_valid, out_pixel, out_x, out_y, frame_done
  );

  modport slave (
    input  in_valid, top, mid, bot, kernel_load, coeff,
    output out_valid, out_pixel, out_x, out_y, frame_done
  );
endinterface

// File: rtl/conv3x3_engine.sv
// 3x3 sliding-window convolution: window capture, nine signed products, adder,
// then shift/clamp to an 8-bit pixel. Fixed 3-cycle latency, no backpressure.
module conv3x3_engine #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int SHIFT  = 0
) (
  input  logic              clk,
  input  logic              reset,
  conv3x3_engine_if.slave   bus
);
  localparam logic [15:0] COL_LAST  = 16'(WIDTH - 1);
  localparam logic [15:0] LINE_LAST = 16'(HEIGHT - 3);

  logic [15:0]        col_q, col_d;
  logic [15:0]        line_q, line_d;
  logic               win_done;
  logic [7:0]         pix_in [3];
  logic [7:0]         win_q [3][3];
  logic signed [7:0]  k_q [9];
  logic signed [7:0]  kw_q [9];
  logic signed [16:0] prod [9];
  logic signed [16:0] p_q [9];
  logic signed [20:0] sum_d, sum_q;
  logic signed [20:0] shifted;
  logic [7:0]         clamp_d;

  logic        v0_q, v1_q, v2_q;
  logic [15:0] x0_q, x1_q, x2_q;
  logic [15:0] y0_q, y1_q, y2_q;
  logic        fd0_q, fd1_q, fd2_q;
  logic        out_valid_q;
  logic [7:0]  out_pixel_q;
  logic [15:0] out_x_q, out_y_q;
  logic        frame_done_q;

  assign pix_in[0] = bus.top;
  assign pix_in[1] = bus.mid;
  assign pix_in[2] = bus.bot;

  always_comb begin
    col_d    = col_q;
    line_d   = line_q;
    win_done = bus.in_valid && (col_q >= 16'd2);
    if (bus.in_valid) begin
      if (col_q == COL_LAST) begin
        col_d  = 16'd0;
        line_d = (line_q == LINE_LAST) ? 16'd0 : line_q + 16'd1;
      end else begin
        col_d = col_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q  <= 16'd0;
      line_q <= 16'd0;
    end else begin
      col_q  <= col_d;
      line_q <= line_d;
    end
  end

  // win_q[r][0] is the leftmost (oldest) column; new pixels enter at [2].
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= 8'd0;
        end
      end
    end else if (bus.in_valid) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
        win_q[r][2] <= pix_in[r];
      end
    end
  end

  // kw_q lags k_q by one cycle, so a window captured on the load edge
  // is multiplied by the kernel that was in force before that edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 9; i++) begin
        k_q[i]  <= (i == 4) ? 8'sd1 : 8'sd0;
        kw_q[i] <= (i == 4) ? 8'sd1 : 8'sd0;
      end
    end else begin
      kw_q <= k_q;
      if (bus.kernel_load) begin
        for (int i = 0; i < 9; i++) begin
          k_q[i] <= $signed(bus.coeff[8*i +: 8]);
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_mul
      assign prod[gi] = 17'($signed({1'b0, win_q[gi/3][gi%3]})) * 17'(kw_q[gi]);
    end
  endgenerate

  always_comb begin
    sum_d = 21'sd0;
    for (int i = 0; i < 9; i++) begin
      sum_d = sum_d + 21'(p_q[i]);
    end
  end

  always_comb begin
    shifted = sum_q >>> SHIFT;
    clamp_d = shifted[7:0];
    if (shifted < 21'sd0) begin
      clamp_d = 8'd0;
    end else if (shifted > 21'sd255) begin
      clamp_d = 8'd255;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v0_q <= 1'b0;  v1_q <= 1'b0;  v2_q <= 1'b0;
      x0_q <= 16'd0; x1_q <= 16'd0; x2_q <= 16'd0;
      y0_q <= 16'd0; y1_q <= 16'd0; y2_q <= 16'd0;
      fd0_q <= 1'b0; fd1_q <= 1'b0; fd2_q <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        p_q[i] <= 17'sd0;
      end
      sum_q        <= 21'sd0;
      out_valid_q  <= 1'b0;
      out_pixel_q  <= 8'd0;
      out_x_q      <= 16'd0;
      out_y_q      <= 16'd0;
      frame_done_q <= 1'b0;
    end else begin
      v0_q  <= win_done;
      x0_q  <= col_q - 16'd1;
      y0_q  <= line_q + 16'd1;
      fd0_q <= win_done && (col_q == COL_LAST) && (line_q == LINE_LAST);

      p_q   <= prod;
      v1_q  <= v0_q;
      x1_q  <= x0_q;
      y1_q  <= y0_q;
      fd1_q <= fd0_q;

      sum_q <= sum_d;
      v2_q  <= v1_q;
      x2_q  <= x1_q;
      y2_q  <= y1_q;
      fd2_q <= fd1_q;

      out_valid_q  <= v2_q;
      frame_done_q <= v2_q && fd2_q;
      if (v2_q) begin
        out_pixel_q <= clamp_d;
        out_x_q     <= x2_q;
        out_y_q     <= y2_q;
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_pixel  = out_pixel_q;
  assign bus.out_x      = out_x_q;
  assign bus.out_y      = out_y_q;
  assign bus.frame_done = frame_done_q;
endmodule
